imul_int_mul_elastic: RTL and testbench
=======================================

# imul_int_mul_elastic

Parametrised, elastic N-stage pipelined integer multiplier for the `imul` subsystem. It is the next generation of the fixed 32-bit N-stage multiplier, and adds:
- configurable operand width;
- RISC-V M-extension operations (low product, plus signed, unsigned and mixed-sign high product);
- per-stage valid/stall, so bubbles are squeezed out and a stalled sink back-pressures only as far as needed.

It sits between a val/rdy request source and a val/rdy response sink, and sustains one multiply per cycle.

## Interface
Parameters:
- `nbits`, 32, operand and result width; must be a multiple of `nstages`.
- `nstages`, 4, number of pipeline registers (1..`nbits`); each stage performs `nbits/nstages` shift-add steps.

Ports:
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `recv_val` input 1: request valid.
- `recv_rdy` output 1: request ready.
- `recv_msg` input 2*`nbits`+2: `{op[1:0], a[nbits-1:0], b[nbits-1:0]}`.
- `send_val` output 1: response valid.
- `send_rdy` input 1: response ready.
- `send_msg` output `nbits`: result.

## Operation
- Op encoding:
  - 0 MUL: low `nbits` of a*b.
  - 1 MULH: signed×signed, high half.
  - 2 MULHSU: signed a × unsigned b, high half.
  - 3 MULHU: unsigned×unsigned, high half.
- Sign handling:
  - At stage-0 capture, take absolute values of the operands flagged signed by the op.
  - Record `neg` = sign(a)^sign(b), counting only the signed operands.
  - Multiply unsigned into a 2*`nbits` accumulator.
  - At the output, two's-complement negate the 2*`nbits` product if `neg` is set, then select the half given by op.
  - Most-negative operands, e.g. 0x80000000 with `nbits`=32, must produce correct results: the magnitude is treated as unsigned `nbits`.
- Per-stage state: valid bit, op, `neg`, shifted multiplicand (2*`nbits`), shifted multiplier (`nbits`), accumulator (2*`nbits`).
- Each step (mirrors the existing step):
  - if b[0], acc += a;
  - then a <<= 1 and b >>= 1.
- Register R0 captures the request. The step group between Ri and Ri+1 advances data. The last group is combinational from R(`nstages`-1) to the output.
- Stall rules:
  - `go_i` = !valid_i || `go_{i+1}`, with `go_last` = !valid_last || `send_rdy`.
  - Ri loads from upstream when `go_i`. Its new valid is the upstream valid (i=0: `recv_val`).
  - `recv_rdy` = `go_0`.
- Arithmetic is modulo 2^(2*`nbits`); there are no overflow flags.

## Timing
- Reset:
  - all valid bits clear;
  - `send_val`=0 and `send_msg`=0;
  - `recv_rdy`=0 while `reset` is high and 1 in the first cycle after it deasserts;
  - datapath registers need no reset.
- Reset mid-operation discards all in-flight requests; no response is produced for them.
- Latency: a request accepted at edge t has `send_val`=1 in the cycle after edge t+`nstages`-1, provided there are no stalls.
- Throughput: 1 request per cycle with `send_rdy` held high.
- `send_msg` is forced to 0 whenever `send_val`=0.
- Stall behaviour:
  - with `send_rdy`=0, the pipeline holds the response stable;
  - empty stages upstream of a stall keep filling;
  - `recv_rdy` falls only when every stage is valid and blocked;
  - `recv_rdy` depends combinationally on `send_rdy`.
- Simultaneous accept on both ends while full: both transfers occur in the same cycle with no bubble.
- Ordering: strictly in order; requests are never dropped or duplicated.

## Configuration
- `IMUL_MULH_EN` defined:
  - all four ops are supported;
  - the accumulator and multiplicand are 2*`nbits` wide;
  - sign conversion and negation logic are present.
- `IMUL_MULH_EN` undefined:
  - the op field is accepted and ignored, and every request computes MUL (low half, unsigned path);
  - accumulator and multiplicand shrink to `nbits`;
  - no sign logic is built.
  - MUL results are bit-identical in both builds.

## Structure
- Package `imul_pkg`:
  - `imul_op_t` enum (MUL, MULH, MULHSU, MULHU);
  - op field width constant;
  - a function returning the message width for a given `nbits`.
- One sub-module, `imul_int_mul_elastic_step`: a combinational single shift-add step, parameterised by `nbits`, instantiated `nbits` times in generate loops.

## Test plan
- Basic MUL: `nbits`=32, `nstages`=4, MUL 3×4, `send_rdy`=1 → 12 appears exactly 4 cycles after acceptance.
- High ops:
  - MULH 0xFFFFFFFF×0xFFFFFFFF → 0x00000000;
  - MULHU same operands → 0xFFFFFFFE;
  - MULHSU 0xFFFFFFFF×0x00000002 → 0xFFFFFFFF;
  - MULH 0x80000000×0x80000000 → 0x40000000.
- Back-to-back streaming: 32 random requests on consecutive cycles with `send_rdy`=1 → 32 responses on consecutive cycles, in order, matching a golden model.
- Sink stall: hold `send_rdy`=0 for 10 cycles while the source keeps `recv_val`=1 → exactly `nstages` requests accepted, `recv_rdy` low afterwards, head response stable; on release, one response per cycle with no bubble.
- Reset mid-stream: assert `reset` with 3 requests in flight → `send_val`=0 the next cycle and no stale responses appear; a new request 5×7 returns 35.
- Parameter sweep and build check: `nbits`=8, `nstages`=1 and `nstages`=8 with random traffic and random `send_rdy` → all results correct; with `IMUL_MULH_EN` undefined, MULHU requests return the low product.

Source files
------------

// File: rtl/imul_pkg.sv
// imul_pkg: op encoding and message sizing shared by the imul multiplier files.
package imul_pkg;
  typedef enum logic [1:0] {MUL = 2'd0, MULH = 2'd1, MULHSU = 2'd2, MULHU = 2'd3} imul_op_t;
  localparam int OP_W = 2;
  function automatic int msg_w(input int nbits);
    return 2 * nbits + OP_W;
  endfunction
endpackage

// File: rtl/imul_int_mul_elastic_step.sv
// imul_int_mul_elastic_step: one combinational shift-add multiply step.
module imul_int_mul_elastic_step #(
  parameter int nbits = 32,
  parameter int aw = 2 * nbits
) (
  input  logic [aw-1:0]    i_a,
  input  logic [nbits-1:0] i_b,
  input  logic [aw-1:0]    i_acc,
  output logic [aw-1:0]    o_a,
  output logic [nbits-1:0] o_b,
  output logic [aw-1:0]    o_acc
);
  assign o_acc = i_b[0] ? i_acc + i_a : i_acc;
  assign o_a = i_a << 1;
  assign o_b = i_b >> 1;
endmodule

// File: rtl/imul_int_mul_elastic.sv
// imul_int_mul_elastic: elastic nstages-deep shift-add multiplier with per-stage valid/stall.
// Define IMUL_MULH_EN for the MULH/MULHSU/MULHU ops; otherwise every request computes MUL.
module imul_int_mul_elastic
  import imul_pkg::*;
#(
  parameter int nbits = 32,
  parameter int nstages = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      recv_val,
  output logic                      recv_rdy,
  input  logic [msg_w(nbits)-1:0]   recv_msg,
  output logic                      send_val,
  input  logic                      send_rdy,
  output logic [nbits-1:0]          send_msg
);
`ifdef IMUL_MULH_EN
  localparam int W = 2 * nbits;
`else
  localparam int W = nbits;
`endif
  localparam int S = nbits / nstages;
  localparam int L = nstages - 1;
  imul_op_t w_op;
  logic [nbits-1:0] w_ra, w_rb, w_ma, w_mb, w_res;
  logic w_neg, w_unused;
  assign w_op = imul_op_t'(recv_msg[2*nbits +: OP_W]);
  assign w_ra = recv_msg[nbits +: nbits];
  assign w_rb = recv_msg[0 +: nbits];
`ifdef IMUL_MULH_EN
  logic w_sa, w_sb;
  assign w_sa = w_op == MULH || w_op == MULHSU;
  assign w_sb = w_op == MULH;
  // magnitudes stay unsigned nbits, so the most-negative operand needs no extra bit
  assign w_ma = w_sa && w_ra[nbits-1] ? -w_ra : w_ra;
  assign w_mb = w_sb && w_rb[nbits-1] ? -w_rb : w_rb;
  assign w_neg = (w_sa & w_ra[nbits-1]) ^ (w_sb & w_rb[nbits-1]);
`else
  assign w_ma = w_ra;
  assign w_mb = w_rb;
  assign w_neg = 1'b0;
`endif
  for (genvar g = 0; g < nstages; g++) begin : g_s
    logic r_val, r_neg, w_go, w_vi, w_negi;
    imul_op_t r_op, w_opi;
    logic [W-1:0] r_a, r_acc, w_ai, w_acci;
    logic [nbits-1:0] r_b, w_bi;
    for (genvar k = 0; k < S; k++) begin : g_k
      logic [W-1:0] w_a, w_acc;
      logic [nbits-1:0] w_b;
      if (k == 0) begin : g_f
        imul_int_mul_elastic_step #(.nbits(nbits), .aw(W)) u_step (
          .i_a(r_a), .i_b(r_b), .i_acc(r_acc), .o_a(w_a), .o_b(w_b), .o_acc(w_acc));
      end else begin : g_n
        imul_int_mul_elastic_step #(.nbits(nbits), .aw(W)) u_step (
          .i_a(g_k[k-1].w_a), .i_b(g_k[k-1].w_b), .i_acc(g_k[k-1].w_acc),
          .o_a(w_a), .o_b(w_b), .o_acc(w_acc));
      end
    end
    if (g == 0) begin : g_in
      assign w_vi = recv_val;
      assign w_opi = w_op;
      assign w_negi = w_neg;
      assign w_ai = W'(w_ma);
      assign w_bi = w_mb;
      assign w_acci = '0;
    end else begin : g_in
      assign w_vi = g_s[g-1].r_val;
      assign w_opi = g_s[g-1].r_op;
      assign w_negi = g_s[g-1].r_neg;
      assign w_ai = g_s[g-1].g_k[S-1].w_a;
      assign w_bi = g_s[g-1].g_k[S-1].w_b;
      assign w_acci = g_s[g-1].g_k[S-1].w_acc;
    end
    // a stage may load when it is empty or its contents move on this cycle
    if (g == L) begin : g_go
      assign w_go = !r_val || send_rdy;
    end else begin : g_go
      assign w_go = !r_val || g_s[g+1].w_go;
    end
    always_ff @(posedge clk) begin
      if (reset) r_val <= 1'b0;
      else if (w_go) r_val <= w_vi;
    end
    always_ff @(posedge clk) begin
      if (w_go) begin
        r_op <= w_opi;
        r_neg <= w_negi;
        r_a <= w_ai;
        r_b <= w_bi;
        r_acc <= w_acci;
      end
    end
  end
`ifdef IMUL_MULH_EN
  logic [W-1:0] w_prod;
  assign w_prod = g_s[L].r_neg ? -g_s[L].g_k[S-1].w_acc : g_s[L].g_k[S-1].w_acc;
  assign w_res = g_s[L].r_op == MUL ? w_prod[nbits-1:0] : w_prod[W-1:nbits];
  assign w_unused = ^{g_s[L].g_k[S-1].w_a, g_s[L].g_k[S-1].w_b};
`else
  assign w_res = g_s[L].g_k[S-1].w_acc;
  assign w_unused = ^{g_s[L].g_k[S-1].w_a, g_s[L].g_k[S-1].w_b, g_s[L].r_op, g_s[L].r_neg};
`endif
  assign send_val = g_s[L].r_val;
  assign send_msg = send_val ? w_res : '0;
  assign recv_rdy = g_s[0].w_go && !reset;
endmodule

// File: tb/tb_imul_int_mul_elastic.sv
// tb_imul_int_mul_elastic: randomized and directed checks of the elastic multiplier against an arithmetic model.
module tb_imul_int_mul_elastic;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset, recv_val, recv_rdy, send_val, send_rdy;
  logic [65:0] recv_msg;
  logic [31:0] send_msg;
  logic rst8, v8, k8, r1_rdy, r8_rdy, s1_val, s8_val, done8;
  logic [17:0] m8;
  logic [7:0] s1_msg, s8_msg;
  int n_cmp = 0, n_bad = 0, acc_cnt = 0;
  logic [31:0] q[$], q1[$], q8[$];

  imul_int_mul_elastic #(.nbits(32), .nstages(4)) u_dut (
    .clk(clk), .reset(reset), .recv_val(recv_val), .recv_rdy(recv_rdy), .recv_msg(recv_msg),
    .send_val(send_val), .send_rdy(send_rdy), .send_msg(send_msg));
  imul_int_mul_elastic #(.nbits(8), .nstages(1)) u_d1 (
    .clk(clk), .reset(rst8), .recv_val(v8), .recv_rdy(r1_rdy), .recv_msg(m8),
    .send_val(s1_val), .send_rdy(k8), .send_msg(s1_msg));
  imul_int_mul_elastic #(.nbits(8), .nstages(8)) u_d8 (
    .clk(clk), .reset(rst8), .recv_val(v8), .recv_rdy(r8_rdy), .recv_msg(m8),
    .send_val(s8_val), .send_rdy(k8), .send_msg(s8_msg));

  // Reference: exact signed/unsigned product of the n-bit operands, then pick a half.
  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input int n);
    logic signed [127:0] xa, xb, p, m;
    m = (128'sd1 <<< n) - 128'sd1;
    xa = $signed({96'd0, a}) & m;
    xb = $signed({96'd0, b}) & m;
`ifdef IMUL_MULH_EN
    if ((op == 2'd1 || op == 2'd2) && a[n-1]) xa = xa - (128'sd1 <<< n);
    if (op == 2'd1 && b[n-1]) xb = xb - (128'sd1 <<< n);
    p = xa * xb;
    if (op != 2'd0) p = p >>> n;
`else
    p = xa * xb;
`endif
    return 32'(p & m);
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h0;
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (reset) q.delete();
    else begin
      if (send_val && send_rdy && q.size() > 0) void'(q.pop_front());
      if (recv_val && recv_rdy) begin
        q.push_back(ref_mul(recv_msg[65:64], recv_msg[63:32], recv_msg[31:0], 32));
        acc_cnt++;
      end
    end
  end
  always @(negedge clk) begin
    if (!reset) begin
      if (!send_val) chk("idle_zero", send_msg, 32'h0);
      else if (q.size() == 0) chk("unexpected_resp", 32'h1, 32'h0);
      else chk("resp", send_msg, q[0]);
    end
  end

  always @(posedge clk) begin
    if (rst8) begin
      q1.delete();
      q8.delete();
    end else begin
      if (s1_val && k8 && q1.size() > 0) void'(q1.pop_front());
      if (s8_val && k8 && q8.size() > 0) void'(q8.pop_front());
      if (v8 && r1_rdy) q1.push_back(ref_mul(m8[17:16], {24'd0, m8[15:8]}, {24'd0, m8[7:0]}, 8));
      if (v8 && r8_rdy) q8.push_back(ref_mul(m8[17:16], {24'd0, m8[15:8]}, {24'd0, m8[7:0]}, 8));
    end
  end
  always @(negedge clk) begin
    if (!rst8) begin
      if (s1_val) chk("n8s1_resp", {24'd0, s1_msg}, q1.size() > 0 ? q1[0] : 32'hDEAD);
      if (s8_val) chk("n8s8_resp", {24'd0, s8_msg}, q8.size() > 0 ? q8[0] : 32'hDEAD);
    end
  end

  initial begin
    done8 = 1'b0;
    rst8 = 1'b1;
    v8 = 1'b0;
    k8 = 1'b0;
    m8 = '0;
    repeat (3) @(posedge clk);
    #1 rst8 = 1'b0;
    for (int i = 0; i < 500; i++) begin
      v8 = ($urandom % 3) != 0;
      k8 = ($urandom % 2) != 0;
      m8 = 18'($urandom);
      @(posedge clk);
      #1;
    end
    v8 = 1'b0;
    k8 = 1'b1;
    for (int t = 0; t < 100 && (q1.size() + q8.size()) != 0; t++) @(posedge clk);
    @(negedge clk);
    chk("n8_drain", q1.size() + q8.size(), 0);
    done8 = 1'b1;
  end

  task automatic req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int t;
    recv_msg = {op, a, b};
    recv_val = 1'b1;
    for (t = 0; t < 50; t++) begin
      @(negedge clk);
      if (recv_rdy) break;
    end
    if (t == 50) chk("req_timeout", 32'h1, 32'h0);
    @(posedge clk);
    #1 recv_val = 1'b0;
  endtask

  task automatic single(input string nm, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, output int lat);
    int c;
    req(op, a, b);
    for (c = 0; c < 30; c++) begin
      @(negedge clk);
      if (send_val) break;
    end
    lat = c + 1;
    chk(nm, send_msg, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int t;
    for (t = 0; t < 100; t++) begin
      @(negedge clk);
      if (q.size() == 0 && !send_val) break;
    end
    chk("drain", q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat, run, rdyc, a0;
    logic [31:0] h;
    logic hv;
    reset = 1'b1;
    recv_val = 1'b0;
    recv_msg = '0;
    send_rdy = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_send_val", send_val, 0);
    chk("rst_send_msg", send_msg, 0);
    chk("rst_recv_rdy", recv_rdy, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("post_rst_rdy", recv_rdy, 1);
    @(posedge clk);
    #1;

    single("mul_3x4", 2'd0, 32'd3, 32'd4, 32'd12, lat);
    chk("latency", lat, 4);
`ifdef IMUL_MULH_EN
    single("mulh_m1m1", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, lat);
    single("mulhu_m1m1", 2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, lat);
    single("mulhsu_m1x2", 2'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, lat);
    single("mulh_minmin", 2'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, lat);
`else
    single("mulh_m1m1_low", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, lat);
    single("mulhu_m1m1_low", 2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, lat);
    single("mulhsu_m1x2_low", 2'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, lat);
    single("mulh_minmin_low", 2'd1, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, lat);
`endif
    single("mul_wrap", 2'd0, 32'h0001_0001, 32'hFFFF_FFFF, 32'hFFFE_FFFF, lat);

    // back-to-back stream
    a0 = acc_cnt;
    fork
      begin
        for (int i = 0; i < 32; i++) begin
          recv_val = 1'b1;
          recv_msg = {2'($urandom), pick(), pick()};
          @(posedge clk);
          #1;
        end
        recv_val = 1'b0;
      end
      begin
        int c;
        for (c = 0; c < 20; c++) begin
          @(negedge clk);
          if (send_val) break;
        end
        run = send_val ? 1 : 0;
        for (int k = 1; k < 32; k++) begin
          @(negedge clk);
          if (!send_val) break;
          run++;
        end
        chk("b2b_run", run, 32);
      end
    join
    chk("b2b_accepts", acc_cnt - a0, 32);
    drain();

    // sink stall with a busy source
    a0 = acc_cnt;
    hv = 1'b0;
    h = '0;
    send_rdy = 1'b0;
    recv_val = 1'b1;
    for (int i = 0; i < 10; i++) begin
      recv_msg = {2'($urandom), pick(), pick()};
      @(negedge clk);
      if (send_val && !hv) begin
        hv = 1'b1;
        h = send_msg;
      end
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("stall_accepts", acc_cnt - a0, 4);
    chk("stall_rdy_low", recv_rdy, 0);
    chk("stall_head", send_msg, h);
    @(posedge clk);
    #1 send_rdy = 1'b1;
    run = 0;
    rdyc = 0;
    for (int k = 0; k < 8; k++) begin
      recv_msg = {2'($urandom), pick(), pick()};
      @(negedge clk);
      run += send_val ? 1 : 0;
      rdyc += recv_rdy ? 1 : 0;
      @(posedge clk);
      #1;
    end
    chk("release_run", run, 8);
    chk("release_rdy", rdyc, 8);
    recv_val = 1'b0;
    drain();

    // reset with three requests in flight
    for (int i = 0; i < 3; i++) begin
      recv_val = 1'b1;
      recv_msg = {2'd0, pick(), pick()};
      @(posedge clk);
      #1;
    end
    recv_val = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_send_val", send_val, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    single("after_rst_5x7", 2'd0, 32'd5, 32'd7, 32'd35, lat);

    // random traffic with random back-pressure
    for (int i = 0; i < 400; i++) begin
      recv_val = ($urandom % 4) != 0;
      send_rdy = ($urandom % 3) != 0;
      recv_msg = {2'($urandom), pick(), pick()};
      @(posedge clk);
      #1;
    end
    recv_val = 1'b0;
    send_rdy = 1'b1;
    drain();

    for (int t = 0; t < 2000 && !done8; t++) @(posedge clk);
    chk("n8_done", done8, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
